// File: rtl/fetch_queue_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : fetch_queue_pkg
//  Description : Shared IF/ID definitions for the fetch queue. Holds the bus
//                widths, the bit positions of the fields on the IF metadata
//                bus and on the queue output bus, the NOP encoding, and a
//                helper that picks the instruction word for an entry.
//  Revision    : 1.0 - initial release
// ============================================================================
package fetch_queue_pkg;

    // IF metadata bus: {csr_vec_h[64:33], excp_adef[32], pc[31:0]}
    localparam int LA_FS_TO_DS_BUS_WD = 65;
    // Queue output bus: {csr_vec_h[96:65], excp_adef[64], pc[63:32], inst[31:0]}
    localparam int LA_FQ_TO_DS_BUS_WD = 97;

    localparam int FS_PC_LSB   = 0;
    localparam int FS_ADEF_BIT = 32;
    localparam int FS_VEC_LSB  = 33;

    localparam int FQ_INST_LSB = 0;
    localparam int FQ_PC_LSB   = 32;
    localparam int FQ_ADEF_BIT = 64;
    localparam int FQ_VEC_LSB  = 65;

    localparam logic [31:0] INST_NOP = 32'h0340_0000;

    // A fetch that faulted on its address never had valid SRAM data, so the
    // returned word is replaced by a NOP.
    function automatic logic [31:0] fq_pick_inst(input logic i_adef,
                                                 input logic [31:0] i_rdata);
        return i_adef ? INST_NOP : i_rdata;
    endfunction

endpackage : fetch_queue_pkg
`default_nettype wire

// File: rtl/fq_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : fq_fifo
//  Description : Parameterised synchronous FIFO (storage, pointers, count).
//                Flush/reset clear pointers and count; storage is not reset.
//  Ports       : clk, rst       - clock, synchronous active-high reset
//                i_flush        - discard all contents (priority over push/pop)
//                i_push/i_push_data - write one entry at the tail
//                i_pop          - advance the head
//                o_head_data    - entry at the head (don't-care when empty)
//                o_count        - number of held entries
//  Revision    : 1.0 - initial release
// ============================================================================
module fq_fifo #(
    parameter int WIDTH = 97,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       i_flush,
    input  logic                       i_push,
    input  logic [WIDTH-1:0]           i_push_data,
    input  logic                       i_pop,
    output logic [WIDTH-1:0]           o_head_data,
    output logic [$clog2(DEPTH):0]     o_count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [CW-1:0]    r_count;

    // DEPTH is a power of two, so the pointers wrap without explicit compare.
    always_ff @(posedge clk) begin
        if (rst || i_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (i_push) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (i_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            r_count <= r_count + CW'(i_push) - CW'(i_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (i_push && !i_flush && !rst) begin
            r_mem[r_wr_ptr] <= i_push_data;
        end
    end

    assign o_head_data = r_mem[r_rd_ptr];
    assign o_count     = r_count;

endmodule : fq_fifo
`default_nettype wire

// File: rtl/fetch_queue.sv
`default_nettype none
// ============================================================================
//  Module      : fetch_queue
//  Description : IF->ID instruction fetch queue. Pairs each issued fetch's
//                metadata with the SRAM data returned one cycle later, buffers
//                up to FQ_DEPTH entries and presents the oldest to ID.
//                Optional feature macro: FQ_BYPASS_EN - an entry returning into
//                an empty queue is presented combinationally in its return
//                cycle and skips storage when popped right away.
//  Ports       : clk, reset        - clock, synchronous active-high reset
//                flush             - discard all contents and the pending fetch
//                stall[5:0]        - [0] holds IF, [1] holds ID
//                inst_sram_en      - IF issues an SRAM read this cycle
//                fs_to_ds_bus      - metadata of the fetch issued this cycle
//                inst_sram_rdata   - SRAM data for last cycle's fetch
//                fq_stall_req      - queue about to run out of room
//                ds_valid          - head entry valid
//                fq_to_ds_bus      - head entry
//  Revision    : 1.0 - initial release
// ============================================================================
module fetch_queue
    import fetch_queue_pkg::*;
#(
    parameter int FS_TO_DS_BUS_WD = LA_FS_TO_DS_BUS_WD,
    parameter int FQ_TO_DS_BUS_WD = LA_FQ_TO_DS_BUS_WD,
    parameter int FQ_DEPTH        = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       flush,
    input  logic [5:0]                 stall,
    input  logic                       inst_sram_en,
    input  logic [FS_TO_DS_BUS_WD-1:0] fs_to_ds_bus,
    input  logic [31:0]                inst_sram_rdata,
    output logic                       fq_stall_req,
    output logic                       ds_valid,
    output logic [FQ_TO_DS_BUS_WD-1:0] fq_to_ds_bus
);

    localparam int CW = $clog2(FQ_DEPTH) + 1;

    logic                       r_pend_v;
    logic [FS_TO_DS_BUS_WD-1:0] r_pend_meta;

    logic                       w_issue;
    logic                       w_ds_pop;
    logic                       w_fifo_push;
    logic                       w_fifo_pop;
    logic [31:0]                w_ret_inst;
    logic [FQ_TO_DS_BUS_WD-1:0] w_ret_entry;
    logic [FQ_TO_DS_BUS_WD-1:0] w_head_data;
    logic [CW-1:0]              w_count;
    logic [CW:0]                w_occupancy;
    logic                       w_unused_stall;

    // stall[5:2] belong to later stages and do not affect the queue.
    assign w_unused_stall = ^stall[5:2];

    assign w_issue = inst_sram_en & ~stall[0] & ~flush;

    always_ff @(posedge clk) begin
        if (reset || flush) begin
            r_pend_v <= 1'b0;
        end else begin
            r_pend_v <= w_issue;
        end
    end

    always_ff @(posedge clk) begin
        if (w_issue) begin
            r_pend_meta <= fs_to_ds_bus;
        end
    end

    assign w_ret_inst  = fq_pick_inst(r_pend_meta[FS_ADEF_BIT], inst_sram_rdata);
    assign w_ret_entry = {r_pend_meta, w_ret_inst};

    // Counting the in-flight fetch reserves a slot for its return, so a push
    // can never hit a full FIFO.
    assign w_occupancy  = {1'b0, w_count} + (CW+1)'(r_pend_v);
    assign fq_stall_req = (w_occupancy >= (CW+1)'(FQ_DEPTH));

    assign w_ds_pop = ds_valid & ~stall[1] & ~flush;

`ifdef FQ_BYPASS_EN
    logic w_bypass;

    assign w_bypass     = (w_count == '0) & r_pend_v;
    assign ds_valid     = (w_count != '0) | w_bypass;
    assign fq_to_ds_bus = w_bypass ? w_ret_entry : w_head_data;
    // A bypassed entry consumed in its return cycle never enters storage.
    assign w_fifo_push  = r_pend_v & ~flush & ~(w_bypass & w_ds_pop);
    assign w_fifo_pop   = w_ds_pop & ~w_bypass;
`else
    assign ds_valid     = (w_count != '0);
    assign fq_to_ds_bus = w_head_data;
    assign w_fifo_push  = r_pend_v & ~flush;
    assign w_fifo_pop   = w_ds_pop;
`endif

    fq_fifo #(
        .WIDTH (FQ_TO_DS_BUS_WD),
        .DEPTH (FQ_DEPTH)
    ) u_fq_fifo (
        .clk         (clk),
        .rst         (reset),
        .i_flush     (flush),
        .i_push      (w_fifo_push),
        .i_push_data (w_ret_entry),
        .i_pop       (w_fifo_pop),
        .o_head_data (w_head_data),
        .o_count     (w_count)
    );

endmodule : fetch_queue
`default_nettype wire

// File: tb/tb_fetch_queue.sv
`default_nettype none
// ============================================================================
//  Module      : tb_fetch_queue
//  Description : Self-checking bench for fetch_queue. A queue-based model of
//                the fetch queue predicts ds_valid, fq_stall_req and the head
//                entry every cycle; directed sequences add literal checks.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_fetch_queue;

    localparam int          DEPTH = 4;
    localparam logic [31:0] NOP   = 32'h0340_0000;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        flush = 1'b0;
    logic [5:0]  stall = '0;
    logic        inst_sram_en = 1'b0;
    logic [64:0] fs_to_ds_bus = '0;
    logic [31:0] inst_sram_rdata = '0;
    logic        fq_stall_req;
    logic        ds_valid;
    logic [96:0] fq_to_ds_bus;

    fetch_queue dut (
        .clk             (clk),
        .reset           (reset),
        .flush           (flush),
        .stall           (stall),
        .inst_sram_en    (inst_sram_en),
        .fs_to_ds_bus    (fs_to_ds_bus),
        .inst_sram_rdata (inst_sram_rdata),
        .fq_stall_req    (fq_stall_req),
        .ds_valid        (ds_valid),
        .fq_to_ds_bus    (fq_to_ds_bus)
    );

    always #5 clk = ~clk;

    // Model state: entries held, fetch in flight and its metadata.
    logic [96:0] m_q[$];
    logic        m_pend  = 1'b0;
    logic [64:0] m_meta  = '0;
    logic        m_known = 1'b0;
`ifdef FQ_BYPASS_EN
    localparam logic BYP = 1'b1;
`else
    localparam logic BYP = 1'b0;
`endif

    int n_pass  = 0;
    int n_total = 0;

    task automatic chk(input string nm, input logic [96:0] act, input logic [96:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: actual %h required %h", nm, act, exp);
    endtask

    function automatic logic m_valid();
        return (m_q.size() != 0) || (BYP && m_pend);
    endfunction

    function automatic logic m_req();
        return (m_q.size() + int'(m_pend)) >= DEPTH;
    endfunction

    function automatic logic [96:0] m_ret_entry();
        return {m_meta, (m_meta[32] ? NOP : inst_sram_rdata)};
    endfunction

    // Drive one cycle's inputs (the bench plays controller: stall[0] includes
    // the model's stall request), then compare outputs with the model.
    task automatic drive_and_check(input logic en, input logic s0, input logic s1,
                                   input logic fl, input logic rs, input logic [31:0] pc,
                                   input logic adef, input logic [31:0] rd);
        logic [3:0] hi;
        hi = 4'($urandom);
        reset           = rs;
        flush           = fl;
        stall           = {hi, s1, s0 | m_req()};
        inst_sram_en    = en;
        fs_to_ds_bus    = {32'($urandom), adef, pc};
        inst_sram_rdata = rd;
        #1;
        if (m_known) begin
            chk("ds_valid", 97'(ds_valid), 97'(m_valid()));
            chk("fq_stall_req", 97'(fq_stall_req), 97'(m_req()));
            if (m_valid())
                chk("head", fq_to_ds_bus, (m_q.size() != 0) ? m_q[0] : m_ret_entry());
        end
    endtask

    // Apply the clock edge to the model, then move to the next negedge.
    task automatic advance();
        logic v;
        v = m_valid();
        if (reset || flush) begin
            m_q.delete();
            m_pend = 1'b0;
        end else begin
            if (m_pend) m_q.push_back(m_ret_entry());
            if (v && !stall[1]) void'(m_q.pop_front());
            m_pend = inst_sram_en && !stall[0];
            if (m_pend) m_meta = fs_to_ds_bus;
        end
        m_known = 1'b1;
        @(negedge clk);
    endtask

    task automatic step(input logic en, input logic s0, input logic s1,
                        input logic fl, input logic rs, input logic [31:0] pc,
                        input logic adef, input logic [31:0] rd);
        drive_and_check(en, s0, s1, fl, rs, pc, adef, rd);
        advance();
    endtask

    initial begin
        @(negedge clk);
        // Reset, then idle: queue empty, no stall request.
        step(0, 0, 0, 0, 1, 32'h0, 0, 32'h0);
        step(0, 0, 0, 0, 1, 32'h0, 0, 32'h0);
        chk("lit_reset_valid", 97'(ds_valid), 97'(0));
        chk("lit_reset_req", 97'(fq_stall_req), 97'(0));

        // Streaming three fetches back to back.
        step(1, 0, 0, 0, 0, 32'h1c000000, 0, 32'h0);
        step(1, 0, 0, 0, 0, 32'h1c000004, 0, 32'hA);
`ifndef FQ_BYPASS_EN
        chk("lit_stream0_valid", 97'(ds_valid), 97'(1));
        chk("lit_stream0", fq_to_ds_bus[63:0], 97'({32'h1c000000, 32'hA}));
`endif
        step(1, 0, 0, 0, 0, 32'h1c000008, 0, 32'hB);
`ifndef FQ_BYPASS_EN
        chk("lit_stream1", fq_to_ds_bus[63:0], 97'({32'h1c000004, 32'hB}));
`endif
        step(0, 0, 0, 0, 0, 32'h0, 0, 32'hC);
`ifndef FQ_BYPASS_EN
        chk("lit_stream2", fq_to_ds_bus[63:0], 97'({32'h1c000008, 32'hC}));
`endif
        step(0, 0, 0, 0, 0, 32'h0, 0, 32'h0);
        chk("lit_stream_empty", 97'(ds_valid), 97'(0));

        // ADEF entry carries a NOP instead of the SRAM data.
        step(1, 0, 1, 0, 0, 32'h1c000002, 1, 32'h0);
        step(0, 0, 1, 0, 0, 32'h0, 0, 32'hDEADBEEF);
        chk("lit_adef_flag", 97'(fq_to_ds_bus[64]), 97'(1));
        chk("lit_adef_inst", 97'(fq_to_ds_bus[31:0]), 97'(NOP));
        step(0, 0, 0, 0, 0, 32'h0, 0, 32'h0);
        step(0, 0, 0, 0, 0, 32'h0, 0, 32'h0);

        // Full: ID held, IF keeps trying; exactly four entries held.
        for (int i = 0; i < 8; i++)
            step(1, 0, 1, 0, 0, 32'h1c000200 + 32'(4*i), 0, 32'(i));
        chk("lit_full_req", 97'(fq_stall_req), 97'(1));
        chk("lit_full_count", 97'(m_q.size()), 97'(4));
        chk("lit_full_head", 97'(fq_to_ds_bus[63:32]), 97'(32'h1c000200));
        for (int i = 0; i < 6; i++)
            step(0, 0, 0, 0, 0, 32'h0, 0, 32'h0);
        chk("lit_full_drained", 97'(ds_valid), 97'(0));

        // IF stall: requests with stall[0] set issue nothing.
        for (int i = 0; i < 3; i++)
            step(1, 1, 0, 0, 0, 32'h1c000300, 0, 32'h0);
        step(0, 0, 0, 0, 0, 32'h0, 0, 32'h0);
        chk("lit_ifstall_valid", 97'(ds_valid), 97'(0));

        // Flush with two entries held and one fetch in flight.
        step(1, 0, 1, 0, 0, 32'h1c000010, 0, 32'h0);
        step(1, 0, 1, 0, 0, 32'h1c000014, 0, 32'h1);
        step(1, 0, 1, 0, 0, 32'h1c000018, 0, 32'h2);
        step(1, 0, 1, 1, 0, 32'h1c00001c, 0, 32'h3);
        chk("lit_flush_valid", 97'(ds_valid), 97'(0));
        step(0, 0, 0, 0, 0, 32'h0, 0, 32'h12345678);
        chk("lit_flush_drop", 97'(ds_valid), 97'(0));
        step(1, 0, 1, 0, 0, 32'h1c000100, 0, 32'h0);
        step(0, 0, 1, 0, 0, 32'h0, 0, 32'h55);
        chk("lit_after_flush", fq_to_ds_bus[63:0], 97'({32'h1c000100, 32'h55}));
        step(0, 0, 0, 0, 0, 32'h0, 0, 32'h0);
        step(0, 0, 0, 0, 0, 32'h0, 0, 32'h0);

`ifdef FQ_BYPASS_EN
        // Bypass: entry visible in its return cycle, consumed without storage.
        step(1, 0, 0, 0, 0, 32'h1c000400, 0, 32'h0);
        drive_and_check(0, 0, 0, 0, 0, 32'h0, 0, 32'h77);
        chk("lit_bypass_valid", 97'(ds_valid), 97'(1));
        chk("lit_bypass_bus", fq_to_ds_bus[63:0], 97'({32'h1c000400, 32'h77}));
        advance();
        chk("lit_bypass_empty", 97'(ds_valid), 97'(0));
`endif

        // Randomized traffic.
        for (int i = 0; i < 3000; i++) begin
            step(($urandom_range(0, 9) < 7), ($urandom_range(0, 9) < 2),
                 ($urandom_range(0, 9) < 3), ($urandom_range(0, 99) < 3),
                 ($urandom_range(0, 199) == 0), 32'($urandom),
                 ($urandom_range(0, 9) == 0), 32'($urandom));
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule : tb_fetch_queue
`default_nettype wire

// File: doc/fetch_queue.md
# fetch_queue

Instruction fetch queue between the IF and ID stages. It pairs each issued fetch's metadata (PC, ADEF flag, interrupt vector) with the instruction SRAM read data returned one cycle later. It buffers up to FQ_DEPTH complete entries and presents the oldest to ID. When it is about to run out of room it raises a stall request to the pipeline controller. A flush discards everything.

## Interface

Parameters:
- FS_TO_DS_BUS_WD, default 65: IF metadata bus width, {csr_vec_h[64:33], excp_adef[32], pc[31:0]}.
- FQ_TO_DS_BUS_WD, default 97: output bus width, {csr_vec_h[96:65], excp_adef[64], pc[63:32], inst[31:0]}.
- FQ_DEPTH, default 4: number of entries; power of two, at least 2.

Ports:
- Clocking: one clock; reset is synchronous and active-high.
- clk, input, 1: the single clock.
- reset, input, 1: synchronous, active-high.
- flush, input, 1: pipeline redirect; discards all queue contents.
- stall, input, 6: controller stall vector; stall[0] holds IF, stall[1] holds ID.
- inst_sram_en, input, 1: IF's SRAM enable in the current cycle.
- fs_to_ds_bus, input, FS_TO_DS_BUS_WD: metadata of the fetch being issued this cycle.
- inst_sram_rdata, input, 32: SRAM data, valid the cycle after a fetch is issued.
- fq_stall_req, output, 1: stall request to the controller.
- ds_valid, output, 1: the head entry is valid.
- fq_to_ds_bus, output, FQ_TO_DS_BUS_WD: the head entry.

## Operation

- **Issue.** issue = inst_sram_en & ~stall[0] & ~flush. On issue, fs_to_ds_bus is captured into a pending register and pend_v is set to 1. Otherwise pend_v is cleared to 0.
- **Return.**
  - When pend_v = 1, the entry {pending meta, inst} is pushed at the tail.
  - inst = inst_sram_rdata if excp_adef = 0; otherwise inst = 32'h0340_0000 (nop).
- **Pop.** pop = ds_valid & ~stall[1]. The head pointer advances.
- **Push and pop in the same cycle** are both performed; count is unchanged.
- **Count arithmetic.** count is clog2(FQ_DEPTH)+1 bits wide. Pointers are clog2(FQ_DEPTH) bits wide and wrap naturally.
- **Stall request.** fq_stall_req = (count + pend_v) >= FQ_DEPTH, computed combinationally from registered state. With this rule an in-flight return always has a free slot, so no overflow is possible.
  - The controller ORs fq_stall_req into stall[0], which suppresses issue in that same cycle.
- **Outputs.** ds_valid = (count != 0). fq_to_ds_bus = the head entry; it is don't-care when ds_valid = 0.
- **Flush** has priority over issue, push and pop.
  - count, both pointers and pend_v are cleared to 0.
  - SRAM data returning in the cycle after the flush belongs to a discarded fetch. It is dropped because pend_v = 0.
- **Reset** does the same as flush. Storage contents are not reset.
- **Reset mid-operation** discards all entries; ds_valid = 0 and fq_stall_req = 0 in the following cycle.

## Timing

- Fetch issued in cycle T → push at the T+1 edge → ds_valid = 1 in cycle T+2 (without bypass).
- One entry per cycle is sustained while ID is not stalled.
- Output values after reset or flush: ds_valid = 0, fq_stall_req = 0.
- Capacity boundary (FQ_DEPTH = 4, count = 3, pend_v = 1): fq_stall_req = 1 and no issue occurs. If a pop happens in the same cycle, fq_stall_req drops in the next cycle.
- When stall[1] = 1, the head is held stable: fq_to_ds_bus is unchanged and ds_valid stays at 1.

## Configuration

- **FQ_BYPASS_EN defined:**
  - When count = 0 and pend_v = 1, the returning entry is presented combinationally: ds_valid = 1 and fq_to_ds_bus = {pending meta, inst} in cycle T+1.
  - If it is popped in that cycle, it is not written into storage.
  - fq_stall_req is unchanged.
- **FQ_BYPASS_EN undefined:** outputs come only from storage, with the latency given under Timing.

## Structure

- The shared lacpu definitions package/header holds:
  - the FS_TO_DS_BUS_WD and FQ_TO_DS_BUS_WD widths;
  - field bit-position constants;
  - the NOP encoding 32'h0340_0000.
- One sub-module, fq_fifo: a parameterised synchronous FIFO (storage, pointers, count) with push, pop and flush ports. Pending/return pairing, stall logic and bypass stay in fetch_queue.

## Test plan

- **Streaming.** Issue PCs 0x1c000000, 0x1c000004 and 0x1c000008 on back-to-back cycles, returning rdata 0xA, 0xB and 0xC, with no stalls. → ds_valid from T+2; the bus shows pc/inst pairs in order, one per cycle.
- **ADEF.** Issue pc = 0x1c000002 with excp_adef = 1 and rdata = 0xDEADBEEF. → Entry has excp_adef = 1 and inst = 0x03400000.
- **Full.** Hold stall[1] = 1 and issue continuously. → fq_stall_req = 1 once count + pend_v = 4; exactly 4 entries are held; release stall[1] → the 4 entries drain in order with no loss or duplication.
- **IF stall.** inst_sram_en = 1 with stall[0] = 1 for 3 cycles. → No entries are pushed; count is unchanged.
- **Flush with pending.** Flush while count = 2 and pend_v = 1, with rdata 0x12345678 arriving the next cycle. → ds_valid = 0 the next cycle; the rdata is never output; the next issue of pc = 0x1c000100 is output correctly.
- **Bypass (FQ_BYPASS_EN).** Empty queue, issue at T. → ds_valid = 1 at T+1 with the correct pc/inst; count remains 0 after the pop.
